// File: rtl/pipe_ctrl.sv
// pipe_ctrl: fetch PC, IF/ID register, decode-stage redirect and stage-valid chain for a 5-stage MIPS pipeline.
// Performance counters exist only when PIPE_PERF_CNT_EN is defined; otherwise the counter outputs are tied to 0.
module pipe_ctrl #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int               CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stallF,
  input  logic             stallD,
  input  logic             flushE,
  input  logic             pcsrcD,
  input  logic [WIDTH-1:0] pcbranchD,
  input  logic             jumpD,
  input  logic [WIDTH-1:0] pcjumpD,
  input  logic [WIDTH-1:0] instrF,
  output logic [WIDTH-1:0] pcF,
  output logic [WIDTH-1:0] instrD,
  output logic [WIDTH-1:0] pcplus4D,
  output logic             validD,
  output logic             validE,
  output logic             validM,
  output logic             validW,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] retired_cnt
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] ifid_instr_q, ifid_instr_d;
  logic [WIDTH-1:0] ifid_pcplus4_q, ifid_pcplus4_d;
  logic             valid_dec_q, valid_dec_d;
  logic             valid_exe_q, valid_exe_d;
  logic             valid_mem_q, valid_mem_d;
  logic             valid_wb_q, valid_wb_d;
  logic [WIDTH-1:0] pcplus4_f;
  logic             redirect;

  always_comb begin
    redirect  = (pcsrcD | jumpD) & ~stallD;
    pcplus4_f = pc_q + WIDTH'(4);

    // A branch held in D by stallD must not redirect until the stall clears.
    pc_d = pcplus4_f;
    if (stallF) begin
      pc_d = pc_q;
    end else if (jumpD && !stallD) begin
      pc_d = pcjumpD;
    end else if (pcsrcD && !stallD) begin
      pc_d = pcbranchD;
    end

    ifid_instr_d   = ifid_instr_q;
    ifid_pcplus4_d = ifid_pcplus4_q;
    valid_dec_d    = valid_dec_q;
    if (!stallD) begin
      if (redirect) begin
        ifid_instr_d   = '0;
        ifid_pcplus4_d = '0;
        valid_dec_d    = 1'b0;
      end else begin
        ifid_instr_d   = instrF;
        ifid_pcplus4_d = pcplus4_f;
        valid_dec_d    = 1'b1;
      end
    end

    // flushE wins even under stallD so a load-use bubble enters E.
    valid_exe_d = flushE ? 1'b0 : valid_dec_q;
    valid_mem_d = valid_exe_q;
    valid_wb_d  = valid_mem_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q           <= RESET_PC;
      ifid_instr_q   <= '0;
      ifid_pcplus4_q <= '0;
      valid_dec_q    <= 1'b0;
      valid_exe_q    <= 1'b0;
      valid_mem_q    <= 1'b0;
      valid_wb_q     <= 1'b0;
    end else begin
      pc_q           <= pc_d;
      ifid_instr_q   <= ifid_instr_d;
      ifid_pcplus4_q <= ifid_pcplus4_d;
      valid_dec_q    <= valid_dec_d;
      valid_exe_q    <= valid_exe_d;
      valid_mem_q    <= valid_mem_d;
      valid_wb_q     <= valid_wb_d;
    end
  end

  assign pcF      = pc_q;
  assign instrD   = ifid_instr_q;
  assign pcplus4D = ifid_pcplus4_q;
  assign validD   = valid_dec_q;
  assign validE   = valid_exe_q;
  assign validM   = valid_mem_q;
  assign validW   = valid_wb_q;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0] retired_cnt_q, retired_cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && !(&v)) ? v + CNT_W'(1) : v;
  endfunction

  always_comb begin
    stall_cnt_d   = sat_inc(stall_cnt_q, stallF);
    bubble_cnt_d  = sat_inc(bubble_cnt_q, flushE | redirect);
    retired_cnt_d = sat_inc(retired_cnt_q, valid_wb_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q   <= '0;
      bubble_cnt_q  <= '0;
      retired_cnt_q <= '0;
    end else begin
      stall_cnt_q   <= stall_cnt_d;
      bubble_cnt_q  <= bubble_cnt_d;
      retired_cnt_q <= retired_cnt_d;
    end
  end

  assign stall_cnt   = stall_cnt_q;
  assign bubble_cnt  = bubble_cnt_q;
  assign retired_cnt = retired_cnt_q;
`else
  assign stall_cnt   = '0;
  assign bubble_cnt  = '0;
  assign retired_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed vector table, mid-cycle reset, counter saturation and a randomized run vs. a reference model.
module tb_pipe_ctrl;
  localparam int          W   = 32;
  localparam int          CW  = 4;
  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam logic [31:0] I1  = 32'h2008_0005;
  localparam logic [31:0] I2  = 32'h8c09_0004;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          stallF = 1'b0, stallD = 1'b0, flushE = 1'b0, pcsrcD = 1'b0, jumpD = 1'b0;
  logic [W-1:0]  pcbranchD = '0, pcjumpD = '0, instrF = '0;
  logic [W-1:0]  pcF, instrD, pcplus4D;
  logic          validD, validE, validM, validW;
  logic [CW-1:0] stall_cnt, bubble_cnt, retired_cnt;

  int total = 0;
  int bad   = 0;

  pipe_ctrl #(.WIDTH(W), .RESET_PC(RPC), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .stallF(stallF), .stallD(stallD), .flushE(flushE),
    .pcsrcD(pcsrcD), .pcbranchD(pcbranchD), .jumpD(jumpD), .pcjumpD(pcjumpD),
    .instrF(instrF), .pcF(pcF), .instrD(instrD), .pcplus4D(pcplus4D),
    .validD(validD), .validE(validE), .validM(validM), .validW(validW),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  // Expected counter value given the number of qualifying events so far.
  function automatic int cnt_exp(input int events);
`ifdef PIPE_PERF_CNT_EN
    return (events > (1 << CW) - 1) ? (1 << CW) - 1 : events;
`else
    return 0 * events;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: pipeline as a list of stage occupancy flags plus event tallies.
  logic [31:0] m_pc, m_instr, m_p4;
  bit          m_occ[4];
  int          m_stalls, m_bubbles, m_retired;

  task automatic model_reset();
    m_pc = RPC; m_instr = '0; m_p4 = '0;
    foreach (m_occ[i]) m_occ[i] = 1'b0;
    m_stalls = 0; m_bubbles = 0; m_retired = 0;
  endtask

  task automatic model_step();
    bit take_jump, take_branch;
    take_jump   = jumpD && !stallD;
    take_branch = pcsrcD && !stallD && !take_jump;
    m_stalls  += int'(stallF);
    m_bubbles += int'(flushE || take_jump || take_branch);
    m_retired += int'(m_occ[3]);
    m_occ[3] = m_occ[2];
    m_occ[2] = m_occ[1];
    m_occ[1] = flushE ? 1'b0 : m_occ[0];
    if (!stallD) begin
      if (take_jump || take_branch) begin
        m_instr = '0; m_p4 = '0; m_occ[0] = 1'b0;
      end else begin
        m_instr = instrF; m_p4 = m_pc + 32'd4; m_occ[0] = 1'b1;
      end
    end
    if (!stallF)
      m_pc = take_jump ? pcjumpD : take_branch ? pcbranchD : m_pc + 32'd4;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".pcF"}, pcF, m_pc);
    chk({tag, ".instrD"}, instrD, m_instr);
    chk({tag, ".pcplus4D"}, pcplus4D, m_p4);
    chk({tag, ".valid"}, {28'd0, validD, validE, validM, validW},
        {28'd0, m_occ[0], m_occ[1], m_occ[2], m_occ[3]});
    chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(cnt_exp(m_stalls)));
    chk({tag, ".bubble_cnt"}, 32'(bubble_cnt), 32'(cnt_exp(m_bubbles)));
    chk({tag, ".retired_cnt"}, 32'(retired_cnt), 32'(cnt_exp(m_retired)));
  endtask

  typedef struct {
    logic        sf, sd, fe, ps, jm;
    logic [31:0] pcb, pcj, ins;
    logic [31:0] e_pc, e_ins, e_p4;
    logic [3:0]  e_v;   // {validD, validE, validM, validW}
    int          e_st, e_bu, e_re;
  } vec_t;

  function automatic vec_t mk(input logic sf, sd, fe, ps, jm,
                              input logic [31:0] pcb, pcj, ins, e_pc, e_ins, e_p4,
                              input logic [3:0] e_v, input int e_st, e_bu, e_re);
    vec_t v;
    v.sf = sf; v.sd = sd; v.fe = fe; v.ps = ps; v.jm = jm;
    v.pcb = pcb; v.pcj = pcj; v.ins = ins;
    v.e_pc = e_pc; v.e_ins = e_ins; v.e_p4 = e_p4; v.e_v = e_v;
    v.e_st = e_st; v.e_bu = e_bu; v.e_re = e_re;
    return v;
  endfunction

  vec_t tbl[12];

  initial begin
    tbl[0]  = mk(0,0,0,0,0, 0,     0,     I1, 32'h4,   I1, 32'h4,   4'b1000, 0,0,0);
    tbl[1]  = mk(0,0,0,0,0, 0,     0,     I1, 32'h8,   I1, 32'h8,   4'b1100, 0,0,0);
    tbl[2]  = mk(1,1,1,0,0, 0,     0,     I1, 32'h8,   I1, 32'h8,   4'b1010, 1,1,0);
    tbl[3]  = mk(1,1,1,0,0, 0,     0,     I1, 32'h8,   I1, 32'h8,   4'b1001, 2,2,0);
    tbl[4]  = mk(0,0,0,0,0, 0,     0,     I1, 32'hC,   I1, 32'hC,   4'b1100, 2,2,1);
    tbl[5]  = mk(0,0,0,1,0, 'h40,  0,     I1, 32'h40,  0,  0,       4'b0110, 2,3,1);
    tbl[6]  = mk(0,0,0,0,0, 0,     0,     I2, 32'h44,  I2, 32'h44,  4'b1011, 2,3,1);
    tbl[7]  = mk(1,1,1,1,0, 'h200, 0,     I1, 32'h44,  I2, 32'h44,  4'b1001, 3,4,2);
    tbl[8]  = mk(0,0,0,1,0, 'h200, 0,     I1, 32'h200, 0,  0,       4'b0100, 3,5,3);
    tbl[9]  = mk(0,0,0,1,1, 'h40,  'h100, I1, 32'h100, 0,  0,       4'b0010, 3,6,3);
    tbl[10] = mk(0,0,0,0,0, 0,     0,     I1, 32'h104, I1, 32'h104, 4'b1001, 3,6,3);
    tbl[11] = mk(0,0,0,0,0, 0,     0,     I1, 32'h108, I1, 32'h108, 4'b1100, 3,6,4);

    // Reset state, checked while reset is still held across clock edges.
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.pcF", pcF, RPC);
    chk("rst.instrD", instrD, 32'h0);
    chk("rst.pcplus4D", pcplus4D, 32'h0);
    chk("rst.valid", {28'd0, validD, validE, validM, validW}, 32'h0);
    chk("rst.cnt", {20'd0, stall_cnt, bubble_cnt, retired_cnt}, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      stallF = tbl[i].sf; stallD = tbl[i].sd; flushE = tbl[i].fe;
      pcsrcD = tbl[i].ps; jumpD = tbl[i].jm;
      pcbranchD = tbl[i].pcb; pcjumpD = tbl[i].pcj; instrF = tbl[i].ins;
      @(posedge clk);
      #1;
      $display("vec %0d: pcF=%h instrD=%h pcplus4D=%h vDEMW=%b%b%b%b cnt=%0d/%0d/%0d",
               i, pcF, instrD, pcplus4D, validD, validE, validM, validW,
               stall_cnt, bubble_cnt, retired_cnt);
      chk($sformatf("vec%0d.pcF", i), pcF, tbl[i].e_pc);
      chk($sformatf("vec%0d.instrD", i), instrD, tbl[i].e_ins);
      chk($sformatf("vec%0d.pcplus4D", i), pcplus4D, tbl[i].e_p4);
      chk($sformatf("vec%0d.valid", i), {28'd0, validD, validE, validM, validW}, {28'd0, tbl[i].e_v});
      chk($sformatf("vec%0d.stall_cnt", i), 32'(stall_cnt), 32'(cnt_exp(tbl[i].e_st)));
      chk($sformatf("vec%0d.bubble_cnt", i), 32'(bubble_cnt), 32'(cnt_exp(tbl[i].e_bu)));
      chk($sformatf("vec%0d.retired_cnt", i), 32'(retired_cnt), 32'(cnt_exp(tbl[i].e_re)));
    end

    // Mid-cycle asynchronous reset: outputs must clear before any clock edge.
    stallF = 1'b1; stallD = 1'b0; flushE = 1'b1; pcsrcD = 1'b0; jumpD = 1'b0;
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    $display("async reset: pcF=%h vDEMW=%b%b%b%b cnt=%0d/%0d/%0d",
             pcF, validD, validE, validM, validW, stall_cnt, bubble_cnt, retired_cnt);
    chk("arst.pcF", pcF, RPC);
    chk("arst.instrD", instrD, 32'h0);
    chk("arst.valid", {28'd0, validD, validE, validM, validW}, 32'h0);
    chk("arst.cnt", {20'd0, stall_cnt, bubble_cnt, retired_cnt}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();

    // Counter saturation: stallF held for 20 cycles.
    stallF = 1'b1; flushE = 1'b0; instrF = I1;
    for (int i = 0; i < 20; i++) begin
      model_step();
      @(posedge clk);
      #1;
    end
    $display("saturation: pcF=%h stall_cnt=%0d", pcF, stall_cnt);
    chk("sat.stall_cnt", 32'(stall_cnt), 32'(cnt_exp(20)));
    chk_model("sat");

    // Randomized run against the reference model.
    for (int i = 0; i < 400; i++) begin
      stallF = ($urandom_range(0, 4) == 0);
      stallD = stallF ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0);
      flushE = ($urandom_range(0, 5) == 0);
      pcsrcD = ($urandom_range(0, 3) == 0);
      jumpD  = ($urandom_range(0, 6) == 0);
      pcbranchD = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
      pcjumpD   = $urandom() & 32'hFFFF_FFFC;
      instrF    = $urandom();
      model_step();
      @(posedge clk);
      #1;
      $display("rnd %0d: sF=%b sD=%b fE=%b br=%b j=%b pcF=%h vDEMW=%b%b%b%b",
               i, stallF, stallD, flushE, pcsrcD, jumpD, pcF, validD, validE, validM, validW);
      chk_model($sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
